// File: rtl/store_align_unit.sv
// Store-path aligner: turns a (addr, data, size) store into one or two
// bus-word-aligned memory writes with byte strobes, or rejects it with err.
module store_align_unit #(
  parameter int XLEN             = 32,
  parameter int ADDR_W           = 32,
  parameter bit ALLOW_MISALIGNED = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [ADDR_W-1:0]   in_addr,
  input  logic [XLEN-1:0]     in_data,
  input  logic [1:0]          in_size,
  output logic                mem_valid,
  input  logic                mem_ready,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [XLEN-1:0]     mem_wdata,
  output logic [XLEN/8-1:0]   mem_wstrb,
  output logic                done,
  output logic                err
);

  localparam int SW   = XLEN / 8;
  localparam int OFFW = $clog2(SW);

  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1} state_t;

  state_t              state_reg, state_next;
  logic                mem_valid_reg, mem_valid_next;
  logic [ADDR_W-1:0]   mem_addr_reg, mem_addr_next;
  logic [XLEN-1:0]     mem_wdata_reg, mem_wdata_next;
  logic [SW-1:0]       mem_wstrb_reg, mem_wstrb_next;
  logic [XLEN-1:0]     hi_data_reg, hi_data_next;
  logic [SW-1:0]       hi_strb_reg, hi_strb_next;
  logic                done_reg, done_next;
  logic                err_reg, err_next;

  logic [OFFW-1:0]     off;
  logic [3:0]          nb;
  logic [SW-1:0]       lane_mask;
  logic [XLEN-1:0]     data_masked;
  logic [2*XLEN-1:0]   sdata;
  logic [2*SW-1:0]     sstrb;
  logic [ADDR_W-1:0]   base;
  logic                misaligned;
  logic                illegal;

  assign off  = in_addr[OFFW-1:0];
  assign nb   = 4'd1 << in_size;
  assign base = {in_addr[ADDR_W-1:OFFW], {OFFW{1'b0}}};

  // Keep only the low nb bytes of the source register
  for (genvar gi = 0; gi < SW; gi++) begin : g_lane
    assign lane_mask[gi]          = (4'(gi) < nb);
    assign data_masked[8*gi +: 8] = lane_mask[gi] ? in_data[8*gi +: 8] : 8'h00;
  end

  assign sdata = {{XLEN{1'b0}}, data_masked} << {off, 3'b000};
  assign sstrb = {{SW{1'b0}}, lane_mask} << off;

  always_comb begin
    misaligned = 1'b0;
    case (in_size)
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = in_addr[0];
      2'b10:   misaligned = |in_addr[1:0];
      default: misaligned = |in_addr[2:0];
    endcase
  end

  assign illegal = ((XLEN == 32) && (in_size == 2'b11)) ||
                   (!ALLOW_MISALIGNED && misaligned);

  always_comb begin
    state_next     = state_reg;
    mem_valid_next = mem_valid_reg;
    mem_addr_next  = mem_addr_reg;
    mem_wdata_next = mem_wdata_reg;
    mem_wstrb_next = mem_wstrb_reg;
    hi_data_next   = hi_data_reg;
    hi_strb_next   = hi_strb_reg;
    done_next      = 1'b0;
    err_next       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (in_valid) begin
          if (illegal) begin
            err_next = 1'b1;
          end else begin
            state_next     = BEAT0;
            mem_valid_next = 1'b1;
            mem_addr_next  = base;
            mem_wdata_next = sdata[XLEN-1:0];
            mem_wstrb_next = sstrb[SW-1:0];
            hi_data_next   = sdata[2*XLEN-1:XLEN];
            hi_strb_next   = sstrb[2*SW-1:SW];
          end
        end
      end
      BEAT0: begin
        if (mem_ready) begin
          if (|hi_strb_reg) begin
            // Second beat follows with no bubble; address wraps naturally
            state_next     = BEAT1;
            mem_addr_next  = mem_addr_reg + ADDR_W'(SW);
            mem_wdata_next = hi_data_reg;
            mem_wstrb_next = hi_strb_reg;
          end else begin
            state_next     = IDLE;
            mem_valid_next = 1'b0;
            done_next      = 1'b1;
          end
        end
      end
      BEAT1: begin
        if (mem_ready) begin
          state_next     = IDLE;
          mem_valid_next = 1'b0;
          done_next      = 1'b1;
        end
      end
      default: begin
        state_next     = IDLE;
        mem_valid_next = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      mem_valid_reg <= 1'b0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
      mem_wstrb_reg <= '0;
      hi_data_reg   <= '0;
      hi_strb_reg   <= '0;
      done_reg      <= 1'b0;
      err_reg       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      mem_valid_reg <= mem_valid_next;
      mem_addr_reg  <= mem_addr_next;
      mem_wdata_reg <= mem_wdata_next;
      mem_wstrb_reg <= mem_wstrb_next;
      hi_data_reg   <= hi_data_next;
      hi_strb_reg   <= hi_strb_next;
      done_reg      <= done_next;
      err_reg       <= err_next;
    end
  end

  assign in_ready  = (state_reg == IDLE);
  assign mem_valid = mem_valid_reg;
  assign mem_addr  = mem_addr_reg;
  assign mem_wdata = mem_wdata_reg;
  assign mem_wstrb = mem_wstrb_reg;
  assign done      = done_reg;
  assign err       = err_reg;

endmodule

// File: tb/tb_store_align_unit.sv
// Directed bench for store_align_unit (XLEN=32): one DUT splitting
// misaligned stores, one rejecting them.
module tb_store_align_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] in_addr;
  logic [31:0] in_data;
  logic [1:0]  in_size;
  logic        mem_ready;

  logic        in_valid0, in_ready0, mem_valid0, done0, err0;
  logic [31:0] mem_addr0, mem_wdata0;
  logic [3:0]  mem_wstrb0;
  logic        in_valid1, in_ready1, mem_valid1, done1, err1;
  logic [31:0] mem_addr1, mem_wdata1;
  logic [3:0]  mem_wstrb1;

  int n_checks = 0;
  int n_fail   = 0;
  int hs_cnt   = 0;
  bit strict_wrote = 1'b0;

  always #5 clk = ~clk;

  store_align_unit #(.XLEN(32), .ADDR_W(32), .ALLOW_MISALIGNED(1'b1)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid0), .in_ready(in_ready0),
    .in_addr(in_addr), .in_data(in_data), .in_size(in_size),
    .mem_valid(mem_valid0), .mem_ready(mem_ready), .mem_addr(mem_addr0),
    .mem_wdata(mem_wdata0), .mem_wstrb(mem_wstrb0), .done(done0), .err(err0)
  );

  store_align_unit #(.XLEN(32), .ADDR_W(32), .ALLOW_MISALIGNED(1'b0)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
    .in_addr(in_addr), .in_data(in_data), .in_size(in_size),
    .mem_valid(mem_valid1), .mem_ready(mem_ready), .mem_addr(mem_addr1),
    .mem_wdata(mem_wdata1), .mem_wstrb(mem_wstrb1), .done(done1), .err(err1)
  );

  always @(posedge clk) begin
    if (rst_n && mem_valid0 && mem_ready) hs_cnt++;
    if (mem_valid1) strict_wrote = 1'b1;
  end

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  size;
    int          beats;
    int          stall;
    logic [31:0] a0, d0;
    logic [3:0]  s0;
    logic [31:0] a1, d1;
    logic [3:0]  s1;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_store(input vec_t v);
    int hs_start;
    hs_start = hs_cnt;
    chk("in_ready_before", in_ready0, 1);
    in_addr = v.addr; in_data = v.data; in_size = v.size;
    in_valid0 = 1'b1; mem_ready = 1'b1;
    cycle();
    in_valid0 = 1'b0;
    for (int b = 0; b < v.beats; b++) begin
      for (int s = 0; s <= v.stall; s++) begin
        mem_ready = (s == v.stall);
        chk("mem_valid", mem_valid0, 1);
        chk("mem_addr",  mem_addr0,  (b == 0) ? v.a0 : v.a1);
        chk("mem_wdata", mem_wdata0, (b == 0) ? v.d0 : v.d1);
        chk("mem_wstrb", mem_wstrb0, (b == 0) ? v.s0 : v.s1);
        chk("done_early", done0, 0);
        chk("in_ready_busy", in_ready0, 0);
        cycle();
      end
    end
    chk("done_pulse", done0, 1);
    chk("err_on_done", err0, 0);
    chk("mem_valid_after", mem_valid0, 0);
    chk("in_ready_done", in_ready0, 1);
    chk("handshakes", hs_cnt - hs_start, v.beats);
    cycle();
    chk("done_one_cycle", done0, 0);
    $display("store addr=0x%08h data=0x%08h size=%0d beats=%0d stall=%0d",
             v.addr, v.data, v.size, v.beats, v.stall);
  endtask

  task automatic do_reject(input bit strict, input logic [31:0] addr, input logic [1:0] size);
    in_addr = addr; in_data = 32'h11223344; in_size = size; mem_ready = 1'b1;
    if (strict) in_valid1 = 1'b1; else in_valid0 = 1'b1;
    cycle();
    in_valid0 = 1'b0; in_valid1 = 1'b0;
    chk("err_pulse", strict ? err1 : err0, 1);
    chk("err_in_ready", strict ? in_ready1 : in_ready0, 1);
    chk("err_no_write", strict ? mem_valid1 : mem_valid0, 0);
    chk("err_no_done", strict ? done1 : done0, 0);
    cycle();
    chk("err_one_cycle", strict ? err1 : err0, 0);
    chk("err_still_idle", strict ? mem_valid1 : mem_valid0, 0);
    $display("reject strict=%0d addr=0x%08h size=%0d", strict, addr, size);
  endtask

  initial begin
    vecs[0] = '{32'h0000_1003, 32'hDEAD_BEAB, 2'd0, 1, 0, 32'h1000, 32'hAB00_0000, 4'b1000, 32'h0, 32'h0, 4'h0};
    vecs[1] = '{32'h0000_2002, 32'h0000_CAFE, 2'd1, 1, 0, 32'h2000, 32'hCAFE_0000, 4'b1100, 32'h0, 32'h0, 4'h0};
    vecs[2] = '{32'h0000_1002, 32'h1122_3344, 2'd2, 2, 0, 32'h1000, 32'h3344_0000, 4'b1100, 32'h1004, 32'h0000_1122, 4'b0011};
    vecs[3] = '{32'h0000_1002, 32'h1122_3344, 2'd2, 2, 3, 32'h1000, 32'h3344_0000, 4'b1100, 32'h1004, 32'h0000_1122, 4'b0011};
    vecs[4] = '{32'hFFFF_FFFE, 32'h1122_3344, 2'd2, 2, 0, 32'hFFFF_FFFC, 32'h3344_0000, 4'b1100, 32'h0, 32'h0000_1122, 4'b0011};
    vecs[5] = '{32'h0000_3000, 32'h1234_56FF, 2'd0, 1, 0, 32'h3000, 32'h0000_00FF, 4'b0001, 32'h0, 32'h0, 4'h0};
    vecs[6] = '{32'h0000_4000, 32'hCAFE_BABE, 2'd2, 1, 1, 32'h4000, 32'hCAFE_BABE, 4'b1111, 32'h0, 32'h0, 4'h0};
    vecs[7] = '{32'h0000_5003, 32'hBEEF_1234, 2'd1, 2, 0, 32'h5000, 32'h3400_0000, 4'b1000, 32'h5004, 32'h0000_0012, 4'b0001};
    vecs[8] = '{32'h0000_6001, 32'hFFFF_ABCD, 2'd1, 1, 0, 32'h6000, 32'h00AB_CD00, 4'b0110, 32'h0, 32'h0, 4'h0};

    rst_n = 1'b0; in_valid0 = 1'b0; in_valid1 = 1'b0; mem_ready = 1'b0;
    in_addr = '0; in_data = '0; in_size = '0;
    repeat (3) cycle();
    rst_n = 1'b1;
    chk("rst_in_ready", in_ready0, 1);
    chk("rst_mem_valid", mem_valid0, 0);
    chk("rst_mem_addr", mem_addr0, 0);
    chk("rst_mem_wdata", mem_wdata0, 0);
    chk("rst_mem_wstrb", mem_wstrb0, 0);
    chk("rst_done", done0, 0);
    chk("rst_err", err0, 0);

    for (int i = 0; i < 9; i++) do_store(vecs[i]);

    do_reject(1'b1, 32'h0000_1002, 2'd2);
    do_reject(1'b1, 32'h0000_2001, 2'd1);
    do_reject(1'b0, 32'h0000_1000, 2'd3);

    // Strict unit still accepts a naturally aligned store
    in_addr = 32'h0000_7004; in_data = 32'h0A0B_0C0D; in_size = 2'd2;
    in_valid1 = 1'b1; mem_ready = 1'b1;
    cycle();
    in_valid1 = 1'b0;
    chk("strict_valid", mem_valid1, 1);
    chk("strict_addr", mem_addr1, 32'h7004);
    chk("strict_wdata", mem_wdata1, 32'h0A0B_0C0D);
    chk("strict_wstrb", mem_wstrb1, 4'hF);
    cycle();
    chk("strict_done", done1, 1);
    strict_wrote = 1'b0;
    $display("store strict addr=0x00007004 aligned word");

    // Reset asserted while the second beat is on the bus
    in_addr = 32'h0000_1002; in_data = 32'h1122_3344; in_size = 2'd2;
    in_valid0 = 1'b1; mem_ready = 1'b1;
    cycle();
    in_valid0 = 1'b0;
    cycle();
    chk("beat1_before_rst", mem_addr0, 32'h1004);
    rst_n = 1'b0; mem_ready = 1'b0;
    cycle();
    chk("rst_abort_valid", mem_valid0, 0);
    chk("rst_abort_ready", in_ready0, 1);
    chk("rst_abort_done", done0, 0);
    rst_n = 1'b1;
    cycle();
    chk("rst_abort_no_late_done", done0, 0);
    chk("rst_abort_idle", mem_valid0, 0);
    $display("reset during beat1 addr=0x00001002");

    chk("strict_never_wrote_misaligned", strict_wrote, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
